// File: rtl/ex_mem_if.sv
// ----------------------------------------------------------------------------
// ex_mem_if
// Bundle of the execute-side and memory-side signals of the EX/MEM pipeline
// register.
//   master : the execute stage. It drives ex_*, hilo_i and cnt_i, and reads
//            mem_*, hilo_o and cnt_o.
//   slave  : the EX/MEM register. It reads ex_*, hilo_i and cnt_i, and drives
//            mem_*, hilo_o and cnt_o.
// Widths follow DATA_W (GPR/HI/LO), ADDR_W (register address) and CNT_W
// (multi-cycle step counter).
// ----------------------------------------------------------------------------
interface ex_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
);
    // execute -> EX/MEM
    logic [ADDR_W-1:0]   ex_wd;
    logic                ex_wreg;
    logic [DATA_W-1:0]   ex_wdata;
    logic [DATA_W-1:0]   ex_hi;
    logic [DATA_W-1:0]   ex_lo;
    logic                ex_whilo;
    logic [2*DATA_W-1:0] hilo_i;
    logic [CNT_W-1:0]    cnt_i;

    // EX/MEM -> memory stage and execute feedback
    logic [ADDR_W-1:0]   mem_wd;
    logic                mem_wreg;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_hi;
    logic [DATA_W-1:0]   mem_lo;
    logic                mem_whilo;
    logic [2*DATA_W-1:0] hilo_o;
    logic [CNT_W-1:0]    cnt_o;

    modport master (
        output ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, hilo_i, cnt_i,
        input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o
    );

    modport slave (
        input  ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, hilo_i, cnt_i,
        output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o
    );
endinterface

// File: rtl/ex_mem.sv
// ----------------------------------------------------------------------------
// ex_mem
// Pipeline register between the execute stage and the memory-access stage.
// It captures the GPR and HI/LO write requests from execute. It also holds
// the 64-bit intermediate product and the step counter of a two-cycle
// multiply-accumulate, and returns them to execute. A saturating counter
// records how many bubbles were inserted.
//
// Ports:
//   clk        : core clock, all state updates on the rising edge
//   rst        : synchronous, active-high reset
//   stall[5:0] : pipeline stall vector. Only bit 3 (execute stalled) and
//                bit 4 (mem stalled) are decoded.
//   flush      : discards the execute-stage content and aborts a multi-cycle op
//   bus        : ex_mem_if.slave. Carries ex_*/hilo_i/cnt_i in and
//                mem_*/hilo_o/cnt_o out.
//   bubble_cnt : saturating count of inserted bubbles
//
// Every output is driven straight from a flop.
// ----------------------------------------------------------------------------
module ex_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2,
    parameter int BUB_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       stall,
    input  logic             flush,
    ex_mem_if.slave          bus,
    output logic [BUB_W-1:0] bubble_cnt
);

    localparam logic [BUB_W-1:0] BUB_MAX = {BUB_W{1'b1}};
    localparam logic [BUB_W-1:0] BUB_ONE = {{(BUB_W-1){1'b0}}, 1'b1};

    // What the next edge does. Reset is handled in the flop block itself.
    typedef enum logic [1:0] {
        ACT_FLUSH   = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_ADVANCE = 2'd2,
        ACT_HOLD    = 2'd3
    } act_e;

    act_e act_s;

    logic [ADDR_W-1:0]   mem_wd_d,    mem_wd_q;
    logic                mem_wreg_d,  mem_wreg_q;
    logic [DATA_W-1:0]   mem_wdata_d, mem_wdata_q;
    logic [DATA_W-1:0]   mem_hi_d,    mem_hi_q;
    logic [DATA_W-1:0]   mem_lo_d,    mem_lo_q;
    logic                mem_whilo_d, mem_whilo_q;
    logic [2*DATA_W-1:0] hilo_d,      hilo_q;
    logic [CNT_W-1:0]    cnt_d,       cnt_q;
    logic [BUB_W-1:0]    bub_d,       bub_q;

    // These stall bits belong to other stages and are deliberately ignored.
    logic unused_stall_s;
    assign unused_stall_s = ^{stall[5], stall[2:0]};

    // Decode flush/stall into a single action. Flush overrides any stall
    // pattern. The illegal stall[3]=0/stall[4]=1 pattern falls into Advance.
    always_comb begin
        act_s = ACT_HOLD;
        if (flush) begin
            act_s = ACT_FLUSH;
        end else if (!stall[3]) begin
            act_s = ACT_ADVANCE;
        end else if (!stall[4]) begin
            act_s = ACT_BUBBLE;
        end else begin
            act_s = ACT_HOLD;
        end
    end

    // Next-state values for every register, selected by the decoded action.
    always_comb begin
        mem_wd_d    = mem_wd_q;
        mem_wreg_d  = mem_wreg_q;
        mem_wdata_d = mem_wdata_q;
        mem_hi_d    = mem_hi_q;
        mem_lo_d    = mem_lo_q;
        mem_whilo_d = mem_whilo_q;
        hilo_d      = hilo_q;
        cnt_d       = cnt_q;
        bub_d       = bub_q;
        case (act_s)
            ACT_FLUSH: begin
                mem_wd_d    = '0;
                mem_wreg_d  = 1'b0;
                mem_wdata_d = '0;
                mem_hi_d    = '0;
                mem_lo_d    = '0;
                mem_whilo_d = 1'b0;
                hilo_d      = '0;
                cnt_d       = '0;
            end
            ACT_BUBBLE: begin
                // A NOP goes to mem while the partial product loops back.
                mem_wd_d    = '0;
                mem_wreg_d  = 1'b0;
                mem_wdata_d = '0;
                mem_hi_d    = '0;
                mem_lo_d    = '0;
                mem_whilo_d = 1'b0;
                hilo_d      = bus.hilo_i;
                cnt_d       = bus.cnt_i;
                if (bub_q == BUB_MAX) begin
                    bub_d = bub_q;
                end else begin
                    bub_d = bub_q + BUB_ONE;
                end
            end
            ACT_ADVANCE: begin
                // HI/LO are captured regardless of ex_whilo. Consumers
                // qualify them with mem_whilo.
                mem_wd_d    = bus.ex_wd;
                mem_wreg_d  = bus.ex_wreg;
                mem_wdata_d = bus.ex_wdata;
                mem_hi_d    = bus.ex_hi;
                mem_lo_d    = bus.ex_lo;
                mem_whilo_d = bus.ex_whilo;
                hilo_d      = '0;
                cnt_d       = '0;
            end
            ACT_HOLD: begin
                bub_d = bub_q;
            end
            default: begin
                bub_d = bub_q;
            end
        endcase
    end

    // State registers. A synchronous reset clears everything, including any
    // multi-cycle op in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wd_q    <= '0;
            mem_wreg_q  <= 1'b0;
            mem_wdata_q <= '0;
            mem_hi_q    <= '0;
            mem_lo_q    <= '0;
            mem_whilo_q <= 1'b0;
            hilo_q      <= '0;
            cnt_q       <= '0;
            bub_q       <= '0;
        end else begin
            mem_wd_q    <= mem_wd_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_wdata_q <= mem_wdata_d;
            mem_hi_q    <= mem_hi_d;
            mem_lo_q    <= mem_lo_d;
            mem_whilo_q <= mem_whilo_d;
            hilo_q      <= hilo_d;
            cnt_q       <= cnt_d;
            bub_q       <= bub_d;
        end
    end

    assign bus.mem_wd    = mem_wd_q;
    assign bus.mem_wreg  = mem_wreg_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_hi    = mem_hi_q;
    assign bus.mem_lo    = mem_lo_q;
    assign bus.mem_whilo = mem_whilo_q;
    assign bus.hilo_o    = hilo_q;
    assign bus.cnt_o     = cnt_q;
    assign bubble_cnt    = bub_q;

endmodule

// File: tb/tb_ex_mem.sv
// ----------------------------------------------------------------------------
// tb_ex_mem
// Self-checking bench for ex_mem, with BUB_W set to 4 so that saturation is
// quick to reach.
//   1. A table of directed vectors, each holding {inputs, expected outputs}.
//   2. Hand-written sequences for bubble-counter saturation and for reset.
//   3. Random stimulus checked against a rule-level reference model.
// ----------------------------------------------------------------------------
module tb_ex_mem;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;
    localparam int BUB_W  = 4;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic [5:0]  stall;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [63:0] hilo_i;
        logic [1:0]  cnt_i;
    } in_t;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
        logic [3:0]  bub;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [5:0]       stall;
    logic             flush;
    logic [BUB_W-1:0] bubble_cnt;

    int n_cmp;
    int n_bad;

    ex_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    ex_mem #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W),
        .BUB_W (BUB_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .bus       (bus),
        .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk_in(logic r, logic f, logic [5:0] s, logic [4:0] wd,
                                  logic wreg, logic [31:0] wdata, logic [31:0] hi,
                                  logic [31:0] lo, logic whilo, logic [63:0] hilo_i,
                                  logic [1:0] cnt_i);
        in_t v;
        v.rst = r; v.flush = f; v.stall = s; v.wd = wd; v.wreg = wreg;
        v.wdata = wdata; v.hi = hi; v.lo = lo; v.whilo = whilo;
        v.hilo_i = hilo_i; v.cnt_i = cnt_i;
        return v;
    endfunction

    function automatic out_t mk_out(logic [4:0] wd, logic wreg, logic [31:0] wdata,
                                    logic [31:0] hi, logic [31:0] lo, logic whilo,
                                    logic [63:0] hilo, logic [1:0] cnt, logic [3:0] bub);
        out_t o;
        o.wd = wd; o.wreg = wreg; o.wdata = wdata; o.hi = hi; o.lo = lo;
        o.whilo = whilo; o.hilo = hilo; o.cnt = cnt; o.bub = bub;
        return o;
    endfunction

    // Reference model built from the behavioural rules in priority order.
    function automatic out_t ref_step(out_t cur, in_t i);
        out_t n;
        int   b;
        n = cur;
        if (i.rst) begin
            n = '0;
        end else if (i.flush) begin
            n = '0;
            n.bub = cur.bub;
        end else if (i.stall[3] && !i.stall[4]) begin
            n = '0;
            n.hilo = i.hilo_i;
            n.cnt = i.cnt_i;
            b = int'(cur.bub) + 1;
            n.bub = (b > 15) ? 4'd15 : b[3:0];
        end else if (!i.stall[3]) begin
            n = mk_out(i.wd, i.wreg, i.wdata, i.hi, i.lo, i.whilo, 64'd0, 2'd0, cur.bub);
        end else begin
            n = cur;
        end
        return n;
    endfunction

    task automatic apply(input in_t v);
        rst          = v.rst;
        flush        = v.flush;
        stall        = v.stall;
        bus.ex_wd    = v.wd;
        bus.ex_wreg  = v.wreg;
        bus.ex_wdata = v.wdata;
        bus.ex_hi    = v.hi;
        bus.ex_lo    = v.lo;
        bus.ex_whilo = v.whilo;
        bus.hilo_i   = v.hilo_i;
        bus.cnt_i    = v.cnt_i;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = mk_out(bus.mem_wd, bus.mem_wreg, bus.mem_wdata, bus.mem_hi, bus.mem_lo,
                     bus.mem_whilo, bus.hilo_o, bus.cnt_o, bubble_cnt);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got wd=%h wreg=%b wdata=%h hi=%h lo=%h whilo=%b hilo=%h cnt=%h bub=%h, want wd=%h wreg=%b wdata=%h hi=%h lo=%h whilo=%b hilo=%h cnt=%h bub=%h",
                     name, act.wd, act.wreg, act.wdata, act.hi, act.lo, act.whilo, act.hilo,
                     act.cnt, act.bub, exp.wd, exp.wreg, exp.wdata, exp.hi, exp.lo,
                     exp.whilo, exp.hilo, exp.cnt, exp.bub);
        end
    endtask

    vec_t vecs[17];

    initial begin
        out_t model;
        in_t  v;
        n_cmp = 0;
        n_bad = 0;

        // Directed table. Each row is applied for one edge and then checked.
        vecs[0]  = '{mk_in(1'b1, 1'b0, 6'b000000, 5'd9, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h2, 1'b1, 64'h5, 2'd1),
                     mk_out(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, 4'd0)};
        vecs[1]  = '{mk_in(1'b1, 1'b0, 6'b001111, 5'd9, 1'b1, 32'h1, 32'h1, 32'h2, 1'b1, 64'h5, 2'd1),
                     mk_out(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, 4'd0)};
        vecs[2]  = '{mk_in(1'b0, 1'b0, 6'b000000, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0),
                     mk_out(5'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, 4'd0)};
        vecs[3]  = '{mk_in(1'b0, 1'b0, 6'b000000, 5'd0, 1'b0, 32'h0, 32'hAAAA_0000, 32'h0000_5555, 1'b1, 64'h0, 2'd0),
                     mk_out(5'd0, 1'b0, 32'h0, 32'hAAAA_0000, 32'h0000_5555, 1'b1, 64'h0, 2'd0, 4'd0)};
        vecs[4]  = '{mk_in(1'b0, 1'b0, 6'b001111, 5'd7, 1'b1, 32'h99, 32'h1, 32'h2, 1'b1, 64'h1_0000_0002, 2'd1),
                     mk_out(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h1_0000_0002, 2'd1, 4'd1)};
        vecs[5]  = '{mk_in(1'b0, 1'b0, 6'b000000, 5'd7, 1'b1, 32'hDEAD, 32'h3, 32'h4, 1'b1, 64'h77, 2'd2),
                     mk_out(5'd7, 1'b1, 32'hDEAD, 32'h3, 32'h4, 1'b1, 64'h0, 2'd0, 4'd1)};
        vecs[6]  = '{mk_in(1'b0, 1'b0, 6'b000000, 5'd2, 1'b1, 32'h55, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0),
                     mk_out(5'd2, 1'b1, 32'h55, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, 4'd1)};
        vecs[7]  = '{mk_in(1'b0, 1'b0, 6'b011111, 5'd31, 1'b0, 32'h66, 32'h9, 32'h9, 1'b1, 64'h123, 2'd3),
                     mk_out(5'd2, 1'b1, 32'h55, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, 4'd1)};
        vecs[8]  = '{mk_in(1'b0, 1'b0, 6'b011111, 5'd31, 1'b0, 32'h77, 32'h9, 32'h9, 1'b1, 64'h123, 2'd3),
                     mk_out(5'd2, 1'b1, 32'h55, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, 4'd1)};
        vecs[9]  = '{mk_in(1'b0, 1'b0, 6'b011111, 5'd31, 1'b0, 32'h88, 32'h9, 32'h9, 1'b1, 64'h123, 2'd3),
                     mk_out(5'd2, 1'b1, 32'h55, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, 4'd1)};
        vecs[10] = '{mk_in(1'b0, 1'b0, 6'b001111, 5'd3, 1'b1, 32'h1, 32'h1, 32'h1, 1'b1, 64'hABC, 2'd1),
                     mk_out(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'hABC, 2'd1, 4'd2)};
        vecs[11] = '{mk_in(1'b0, 1'b0, 6'b011111, 5'd3, 1'b1, 32'h1, 32'h1, 32'h1, 1'b1, 64'h1, 2'd2),
                     mk_out(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'hABC, 2'd1, 4'd2)};
        vecs[12] = '{mk_in(1'b0, 1'b1, 6'b001111, 5'd3, 1'b1, 32'h5, 32'h1, 32'h1, 1'b1, 64'h999, 2'd1),
                     mk_out(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, 4'd2)};
        vecs[13] = '{mk_in(1'b0, 1'b0, 6'b010000, 5'd3, 1'b1, 32'h11, 32'h0, 32'h0, 1'b0, 64'h5, 2'd1),
                     mk_out(5'd3, 1'b1, 32'h11, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, 4'd2)};
        vecs[14] = '{mk_in(1'b0, 1'b0, 6'b100111, 5'd4, 1'b0, 32'h22, 32'h7, 32'h8, 1'b0, 64'h5, 2'd1),
                     mk_out(5'd4, 1'b0, 32'h22, 32'h7, 32'h8, 1'b0, 64'h0, 2'd0, 4'd2)};
        vecs[15] = '{mk_in(1'b0, 1'b0, 6'b101000, 5'd1, 1'b1, 32'h3, 32'h0, 32'h0, 1'b0, 64'h5, 2'd1),
                     mk_out(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h5, 2'd1, 4'd3)};
        vecs[16] = '{mk_in(1'b1, 1'b0, 6'b001111, 5'd1, 1'b1, 32'h3, 32'h0, 32'h0, 1'b0, 64'h6, 2'd1),
                     mk_out(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, 4'd0)};

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i].in);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Saturation: 2^4+3 bubbles in a row, then reset clears the count.
        for (int i = 0; i < 19; i++) begin
            apply(mk_in(1'b0, 1'b0, 6'b001000, 5'd1, 1'b1, 32'h1, 32'h1, 32'h1, 1'b1, 64'(i), 2'd1));
            check($sformatf("sat%0d", i),
                  mk_out(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'(i), 2'd1,
                         (i + 1 > 15) ? 4'd15 : 4'(i + 1)));
        end
        apply(mk_in(1'b1, 1'b0, 6'b001000, 5'd1, 1'b1, 32'h1, 32'h1, 32'h1, 1'b1, 64'h1, 2'd1));
        check("sat_rst", mk_out(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, 4'd0));

        // Random stimulus against the reference model. The model starts from
        // the reset state left by the previous step.
        model = '0;
        for (int i = 0; i < 400; i++) begin
            v.rst    = ($urandom_range(39) == 0);
            v.flush  = ($urandom_range(15) == 0);
            v.stall  = 6'($urandom);
            v.wd     = 5'($urandom);
            v.wreg   = 1'($urandom);
            v.wdata  = $urandom;
            v.hi     = $urandom;
            v.lo     = $urandom;
            v.whilo  = 1'($urandom);
            v.hilo_i = {$urandom, $urandom};
            v.cnt_i  = 2'($urandom);
            apply(v);
            model = ref_step(model, v);
            check($sformatf("rand%0d", i), model);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
